// File: rtl/serial_slice_tx.sv
// serial_slice_tx: parallel-in, MSB-first serial transmitter with fixed,
// free-running slot framing matching the serial slice receiver.
// Optional even-parity bit at the end of every slot: define
// SERIAL_SLICE_TX_PARITY_EN (slot becomes WIDTH+1 bits).
module serial_slice_tx #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_frame,
  output logic             out_valid,
  output logic [CNT_W-1:0] sent_count
);

`ifdef SERIAL_SLICE_TX_PARITY_EN
  localparam int unsigned SLOT = WIDTH + 1;
`else
  localparam int unsigned SLOT = WIDTH;
`endif
  localparam int unsigned      POS_W = $clog2(SLOT);
  localparam logic [POS_W-1:0] LAST  = POS_W'(SLOT - 1);

  typedef enum logic {
    IDLE_SLOT,
    DATA_SLOT
  } slot_e;

  slot_e            state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             frame_q, frame_d;
  logic             wrap;
  logic             accept;
`ifdef SERIAL_SLICE_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign wrap       = (pos_q == LAST);
  assign in_ready   = wrap && !reset;
  assign accept     = in_valid && in_ready;

  assign out        = out_q;
  assign out_frame  = frame_q;
  assign out_valid  = (state_q == DATA_SLOT);
  assign sent_count = cnt_q;

  // Next-state: slot position, slot state at wrap, shifter, parity, counter.
  // shreg holds only the bits still to be sent: at load the MSB goes
  // straight to out and the rest is stored pre-shifted, so out is always
  // the registered copy of shreg's MSB with no extra cycle of latency.
  always_comb begin
    pos_d   = wrap ? '0 : pos_q + POS_W'(1);
    state_d = state_q;
    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    out_d   = shreg_q[WIDTH-1];
    cnt_d   = cnt_q;
`ifdef SERIAL_SLICE_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (wrap) begin
      if (state_q == DATA_SLOT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (accept) begin
        state_d = DATA_SLOT;
        shreg_d = {in_data[WIDTH-2:0], 1'b0};
        out_d   = in_data[WIDTH-1];
`ifdef SERIAL_SLICE_TX_PARITY_EN
        par_d   = ^in_data;
`endif
      end else begin
        state_d = IDLE_SLOT;
        shreg_d = '0;
        out_d   = 1'b0;
`ifdef SERIAL_SLICE_TX_PARITY_EN
        par_d   = 1'b0;
`endif
      end
    end
`ifdef SERIAL_SLICE_TX_PARITY_EN
    if (!wrap && (pos_d == POS_W'(WIDTH))) begin
      out_d = par_q;
    end
`endif
    frame_d = (pos_d == '0);
  end

  // State register; synchronous reset restarts framing at the last slot bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE_SLOT;
      pos_q   <= LAST;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      frame_q <= 1'b0;
`ifdef SERIAL_SLICE_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      frame_q <= frame_d;
`ifdef SERIAL_SLICE_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
